// File: rtl/rob_multibank.sv
// Multi-bank reorder buffer.
// Each row holds NBANK aligned instructions from one dispatch packet. Rows enter at
// the tail and retire in order from the head, one per cycle. The buffer supports
// writeback marking, exception recording with a precise partial-row commit and
// flush, and kill/clear of lanes by branch mask.
module rob_multibank #(
  parameter  int NBANK     = 4,
  parameter  int DEPTH     = 8,
  parameter  int WIDTH_DT  = 16,
  parameter  int WIDTH_BRM = 4,
  parameter  int NWB       = 4,
  localparam int RB        = $clog2(DEPTH),
  localparam int LB        = $clog2(NBANK)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_dis_we,
  input  logic [NBANK-1:0]              i_dis_val,
  input  logic [31:0]                   i_dis_pc,
  input  logic [NBANK*WIDTH_DT-1:0]     i_dis_data,
  input  logic [NBANK*WIDTH_BRM-1:0]    i_dis_brmask,
  output logic [RB-1:0]                 o_dis_tag,
  output logic                          o_full,
  output logic                          o_empty,
  input  logic [NWB-1:0]                i_wb_val,
  input  logic [NWB*(RB+LB)-1:0]        i_wb_tag,
  input  logic [NWB-1:0]                i_wb_exc,
  input  logic                          i_kill_en,
  input  logic [WIDTH_BRM-1:0]          i_kill_mask,
  input  logic [WIDTH_BRM-1:0]          i_br_clr,
  output logic                          o_com_en,
  output logic [NBANK-1:0]              o_com_val,
  output logic [NBANK*WIDTH_DT-1:0]     o_com_data,
  output logic                          o_exc_en,
  output logic [31:0]                   o_exc_pc
);

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  logic [RB:0]                           r_head, r_tail;
  logic [NBANK-1:0]                      r_val  [DEPTH];
  logic [NBANK-1:0]                      r_busy [DEPTH];
  logic [NBANK-1:0]                      r_exc  [DEPTH];
  logic [NBANK-1:0][WIDTH_BRM-1:0]       r_brm  [DEPTH];
  logic [NBANK*WIDTH_DT-1:0]             r_data [DEPTH];
  logic [29-LB:0]                        r_pc   [DEPTH];

  logic [RB-1:0]                         w_hidx, w_tidx;
  logic [NBANK-1:0][WIDTH_BRM-1:0]       w_dis_brm;
  logic [NBANK-1:0]                      w_dis_kill;
  logic                                  w_dis_fire;
  logic [RB-1:0]                         w_wb_row  [NWB];
  logic [LB-1:0]                         w_wb_lane [NWB];
  logic [NBANK-1:0]                      w_hv, w_exc_vec, w_lo_mask;
  logic [LB-1:0]                         w_exc_lane;
  logic                                  w_found, w_ready;
  logic [NBANK-1:0]                      w_val_n  [DEPTH];
  logic [NBANK-1:0]                      w_busy_n [DEPTH];
  logic [NBANK-1:0]                      w_exc_n  [DEPTH];
  logic [NBANK-1:0][WIDTH_BRM-1:0]       w_brm_n  [DEPTH];
  logic                                  w_unused_pc;

  assign w_hidx      = r_head[RB-1:0];
  assign w_tidx      = r_tail[RB-1:0];
  assign o_empty     = (r_head == r_tail);
  assign o_full      = (w_hidx == w_tidx) && (r_head[RB] != r_tail[RB]);
  assign o_dis_tag   = w_tidx;
  assign w_dis_brm   = i_dis_brmask;
  assign w_dis_fire  = i_dis_we && !o_full && !o_exc_en;
  // Row PC is aligned to the row size; the offset bits are rebuilt from the lane index.
  assign w_unused_pc = ^i_dis_pc[LB+1:0];

  // Split writeback tags into {row, lane} and flag dispatched lanes hit by a kill.
  always_comb begin
    for (int p = 0; p < NWB; p++) begin
      w_wb_row[p]  = i_wb_tag[p*(RB+LB)+LB +: RB];
      w_wb_lane[p] = i_wb_tag[p*(RB+LB) +: LB];
    end
    for (int k = 0; k < NBANK; k++)
      w_dis_kill[k] = i_kill_en && ((w_dis_brm[k] & i_kill_mask) != '0);
  end

  // Commit decision from the head row: ready, lowest faulting lane, committed lanes.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can infer a latch.
    w_found    = 1'b0;
    w_exc_lane = '0;
    w_lo_mask  = '0;
    o_com_val  = '0;
    o_com_data = '0;
    o_exc_pc   = '0;
    w_hv       = r_val[w_hidx];
    w_exc_vec  = w_hv & r_exc[w_hidx];
    w_ready    = !o_empty && ((w_hv & r_busy[w_hidx]) == '0);
    for (int k = 0; k < NBANK; k++) begin
      if (!w_found) begin
        if (w_exc_vec[k]) begin
          w_found    = 1'b1;
          w_exc_lane = LB'(k);
        end else begin
          w_lo_mask[k] = 1'b1;
        end
      end
    end
    o_com_en = w_ready;
    o_exc_en = w_ready && w_found;
    if (w_ready) begin
      o_com_data = r_data[w_hidx];
      o_com_val  = w_found ? (w_hv & w_lo_mask) : w_hv;
    end
    if (o_exc_en) o_exc_pc = {r_pc[w_hidx], w_exc_lane, 2'b00};
  end

  // Next lane state: writeback, then kill (kill wins), retire, dispatch, flush.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      w_val_n[r]  = r_val[r];
      w_busy_n[r] = r_busy[r];
      w_exc_n[r]  = r_exc[r];
      for (int k = 0; k < NBANK; k++) begin
        w_brm_n[r][k] = r_brm[r][k] & ~i_br_clr;
        for (int p = 0; p < NWB; p++) begin
          if (i_wb_val[p] && (w_wb_row[p] == RB'(r)) && (w_wb_lane[p] == LB'(k)) && r_val[r][k]) begin
            w_busy_n[r][k] = 1'b0;
            w_exc_n[r][k]  = w_exc_n[r][k] | i_wb_exc[p];
          end
        end
        if (i_kill_en && ((r_brm[r][k] & i_kill_mask) != '0)) begin
          w_val_n[r][k]  = 1'b0;
          w_busy_n[r][k] = 1'b0;
        end
      end
    end
    // A retired row is invalidated so late writebacks to its slot are ignored.
    if (o_com_en) begin
      w_val_n[w_hidx]  = '0;
      w_busy_n[w_hidx] = '0;
    end
    if (w_dis_fire) begin
      w_val_n[w_tidx]  = i_dis_val & ~w_dis_kill;
      w_busy_n[w_tidx] = i_dis_val & ~w_dis_kill;
      w_exc_n[w_tidx]  = '0;
      for (int k = 0; k < NBANK; k++)
        w_brm_n[w_tidx][k] = w_dis_brm[k] & ~i_br_clr;
    end
    if (o_exc_en) begin
      for (int r = 0; r < DEPTH; r++) begin
        w_val_n[r]  = '0;
        w_busy_n[r] = '0;
      end
    end
  end

  // Control state and pointers, cleared by asynchronous reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      for (int r = 0; r < DEPTH; r++) begin
        r_val[r]  <= '0;
        r_busy[r] <= '0;
        r_exc[r]  <= '0;
        r_brm[r]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      for (int r = 0; r < DEPTH; r++) begin
        r_val[r]  <= w_val_n[r];
        r_busy[r] <= w_busy_n[r];
        r_exc[r]  <= w_exc_n[r];
        r_brm[r]  <= w_brm_n[r];
      end
      if (o_exc_en) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (o_com_en)   r_head <= r_head + (RB+1)'(1);
        if (w_dis_fire) r_tail <= r_tail + (RB+1)'(1);
      end
    end
  end

  // Payload and row PC storage, written at dispatch.
  // NOTE: no reset here; contents are only observed once the valid bits say so.
  always_ff @(posedge i_clk) begin
    if (w_dis_fire) begin
      r_data[w_tidx] <= i_dis_data;
      r_pc[w_tidx]   <= i_dis_pc[31:LB+2];
    end
  end

endmodule

// File: tb/tb_rob_multibank.sv
// Self-checking bench for rob_multibank: directed scenarios plus random traffic,
// all compared every cycle against an occupancy/queue model of the buffer.
module tb_rob_multibank;
  localparam int NBANK = 4, DEPTH = 8, WIDTH_DT = 16, WIDTH_BRM = 4, NWB = 4;
  localparam int RB = 3, LB = 2, TW = RB + LB;

  logic                       clk = 1'b0, rst_n = 1'b0;
  logic                       dis_we;
  logic [NBANK-1:0]           dis_val;
  logic [31:0]                dis_pc;
  logic [NBANK*WIDTH_DT-1:0]  dis_data;
  logic [NBANK*WIDTH_BRM-1:0] dis_brmask;
  logic [RB-1:0]              dis_tag;
  logic                       full, empty;
  logic [NWB-1:0]             wb_val, wb_exc;
  logic [NWB*TW-1:0]          wb_tag;
  logic                       kill_en;
  logic [WIDTH_BRM-1:0]       kill_mask, br_clr;
  logic                       com_en, exc_en;
  logic [NBANK-1:0]           com_val;
  logic [NBANK*WIDTH_DT-1:0]  com_data;
  logic [31:0]                exc_pc;

  always #5 clk = ~clk;

  rob_multibank #(.NBANK(NBANK), .DEPTH(DEPTH), .WIDTH_DT(WIDTH_DT),
                  .WIDTH_BRM(WIDTH_BRM), .NWB(NWB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_dis_we(dis_we), .i_dis_val(dis_val),
    .i_dis_pc(dis_pc), .i_dis_data(dis_data), .i_dis_brmask(dis_brmask),
    .o_dis_tag(dis_tag), .o_full(full), .o_empty(empty), .i_wb_val(wb_val),
    .i_wb_tag(wb_tag), .i_wb_exc(wb_exc), .i_kill_en(kill_en),
    .i_kill_mask(kill_mask), .i_br_clr(br_clr), .o_com_en(com_en),
    .o_com_val(com_val), .o_com_data(com_data), .o_exc_en(exc_en), .o_exc_pc(exc_pc));

  int n_checks = 0, n_errors = 0;

  // Model: a circular queue described by head index and occupancy count.
  int                          m_head, m_count;
  bit [NBANK-1:0]              m_val [DEPTH], m_busy [DEPTH], m_exc [DEPTH];
  bit [WIDTH_BRM-1:0]          m_brm [DEPTH][NBANK];
  logic [NBANK*WIDTH_DT-1:0]   m_data [DEPTH];
  logic [31:0]                 m_pc [DEPTH];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_head = 0;
    m_count = 0;
    for (int r = 0; r < DEPTH; r++) begin
      m_val[r] = '0; m_busy[r] = '0; m_exc[r] = '0;
      for (int k = 0; k < NBANK; k++) m_brm[r][k] = '0;
    end
  endtask

  function automatic bit m_ready();
    return (m_count > 0) && ((m_val[m_head] & m_busy[m_head]) == '0);
  endfunction

  function automatic int m_exc_lane();
    for (int k = 0; k < NBANK; k++)
      if (m_val[m_head][k] && m_exc[m_head][k]) return k;
    return -1;
  endfunction

  function automatic bit m_occupied(int row);
    return ((row - m_head + DEPTH) % DEPTH) < m_count;
  endfunction

  task automatic idle();
    dis_we = 0; dis_val = '0; dis_pc = '0; dis_data = '0; dis_brmask = '0;
    wb_val = '0; wb_tag = '0; wb_exc = '0; kill_en = 0; kill_mask = '0; br_clr = '0;
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic compare_outputs();
    bit rdy;
    int e;
    logic [NBANK-1:0] cv;
    logic [31:0] epc;
    rdy = m_ready();
    e   = m_exc_lane();
    cv  = '0;
    epc = '0;
    if (rdy) cv = (e >= 0) ? (m_val[m_head] & NBANK'((1 << e) - 1)) : m_val[m_head];
    if (rdy && e >= 0) epc = (m_pc[m_head] & ~32'(NBANK*4 - 1)) + 32'(4*e);
    check("empty", empty, m_count == 0);
    check("full", full, m_count == DEPTH);
    check("dis_tag", dis_tag, (m_head + m_count) % DEPTH);
    check("com_en", com_en, rdy);
    check("com_val", com_val, cv);
    check("com_data", com_data, rdy ? m_data[m_head] : '0);
    check("exc_en", exc_en, rdy && e >= 0);
    check("exc_pc", exc_pc, epc);
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit rdy;
    int e, tail, row, lane, t;
    bit fire, killed;
    logic [WIDTH_BRM-1:0] b;
    rdy  = m_ready();
    e    = m_exc_lane();
    tail = (m_head + m_count) % DEPTH;
    fire = dis_we && (m_count < DEPTH);
    if (rdy && e >= 0) begin
      for (int r = 0; r < DEPTH; r++) begin m_val[r] = '0; m_busy[r] = '0; end
      m_head = 0;
      m_count = 0;
      return;
    end
    for (int p = 0; p < NWB; p++) begin
      if (wb_val[p]) begin
        t = int'(wb_tag[p*TW +: TW]);
        row = t / NBANK;
        lane = t % NBANK;
        if (m_occupied(row) && m_val[row][lane]) begin
          m_busy[row][lane] = 0;
          m_exc[row][lane]  = m_exc[row][lane] | wb_exc[p];
        end
      end
    end
    for (int r = 0; r < DEPTH; r++)
      for (int k = 0; k < NBANK; k++) begin
        if (kill_en && m_occupied(r) && ((m_brm[r][k] & kill_mask) != 0)) begin
          m_val[r][k] = 0;
          m_busy[r][k] = 0;
        end
        m_brm[r][k] = m_brm[r][k] & ~br_clr;
      end
    if (rdy) begin
      m_head = (m_head + 1) % DEPTH;
      m_count--;
    end
    if (fire) begin
      for (int k = 0; k < NBANK; k++) begin
        b = dis_brmask[k*WIDTH_BRM +: WIDTH_BRM];
        killed = kill_en && ((b & kill_mask) != 0);
        m_val[tail][k]  = dis_val[k] && !killed;
        m_busy[tail][k] = dis_val[k] && !killed;
        m_exc[tail][k]  = 0;
        m_brm[tail][k]  = b & ~br_clr;
      end
      m_data[tail] = dis_data;
      m_pc[tail]   = dis_pc;
      m_count++;
    end
  endtask

  // One cycle: check outputs, update the model, clock, return idle at the next falling edge.
  task automatic tick();
    compare_outputs();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_tag", dis_tag, 0);
    check("rst_com_en", com_en, 0);
    check("rst_com_val", com_val, 0);
    check("rst_exc_en", exc_en, 0);
    check("rst_exc_pc", exc_pc, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic set_dispatch(logic [NBANK-1:0] v, logic [31:0] pc, logic [63:0] d, logic [15:0] bm);
    dis_we = 1; dis_val = v; dis_pc = pc; dis_data = d; dis_brmask = bm;
  endtask

  task automatic wb_row(int row);
    for (int p = 0; p < NWB; p++) begin
      wb_val[p] = 1;
      wb_tag[p*TW +: TW] = TW'(row*NBANK + p);
    end
  endtask

  initial begin
    idle();
    @(negedge clk);
    do_reset();

    // 1: three full rows, all written back, retire in order.
    set_dispatch(4'hF, 32'h100, 64'h1111_2222_3333_4444, '0); tick();
    set_dispatch(4'hF, 32'h110, 64'h5555_6666_7777_8888, '0); tick();
    set_dispatch(4'hF, 32'h120, 64'h9999_aaaa_bbbb_cccc, '0); tick();
    wb_row(0); tick();
    check("t1_com_en0", com_en, 1);
    check("t1_com_val0", com_val, 4'hF);
    check("t1_data0", com_data, 64'h1111_2222_3333_4444);
    wb_row(1); tick();
    check("t1_data1", com_data, 64'h5555_6666_7777_8888);
    wb_row(2); tick();
    check("t1_data2", com_data, 64'h9999_aaaa_bbbb_cccc);
    tick();
    check("t1_empty", empty, 1);

    // 2: fill to full, overflow dropped, one retire frees a slot at tag 0.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_dispatch(4'hF, 32'h400 + 32'(16*i), 64'(i), '0); tick();
    end
    check("t2_full", full, 1);
    set_dispatch(4'hF, 32'h800, 64'hdead, '0); tick();
    check("t2_full_held", full, 1);
    check("t2_tag", dis_tag, 0);
    wb_row(0); tick();
    check("t2_retire", com_en, 1);
    tick();
    check("t2_not_full", full, 0);
    check("t2_tag0", dis_tag, 0);
    set_dispatch(4'h3, 32'h900, 64'hbeef, '0); tick();
    check("t2_full_again", full, 1);

    // 3: exception on lane 2 -> partial commit, then flush.
    do_reset();
    set_dispatch(4'hF, 32'h200, 64'h0123_4567_89ab_cdef, '0); tick();
    wb_row(0); wb_exc = 4'b0100; tick();
    check("t3_com_val", com_val, 4'b0011);
    check("t3_exc_en", exc_en, 1);
    check("t3_exc_pc", exc_pc, 32'h208);
    set_dispatch(4'hF, 32'h300, 64'h1, '0); tick();
    check("t3_empty", empty, 1);
    check("t3_tag", dis_tag, 0);

    // 4: kill by branch mask; kill beats writeback on the same lane.
    do_reset();
    set_dispatch(4'hF, 32'h500, 64'haa, 16'h1111); tick();
    set_dispatch(4'hF, 32'h510, 64'hbb, 16'h2222); tick();
    kill_en = 1; kill_mask = 4'b0001; wb_val = 4'b0001; wb_tag[TW-1:0] = TW'(0); tick();
    check("t4_bubble_en", com_en, 1);
    check("t4_bubble_val", com_val, 0);
    tick();
    wb_row(1); tick();
    check("t4_second", com_val, 4'hF);
    tick();

    // 5: branch clear protects lanes from a later kill on that bit.
    do_reset();
    set_dispatch(4'hF, 32'h600, 64'hcc, 16'h1111); tick();
    br_clr = 4'b0001; tick();
    kill_en = 1; kill_mask = 4'b0001; tick();
    wb_row(0); tick();
    check("t5_survive", com_val, 4'hF);
    tick();

    // 6: asynchronous reset with busy rows, then dispatch resumes at tag 0.
    for (int i = 0; i < 5; i++) begin
      set_dispatch(4'hF, 32'h700 + 32'(16*i), 64'(i), '0); tick();
    end
    do_reset();
    check("t6_tag0", dis_tag, 0);
    set_dispatch(4'h1, 32'h0, 64'h7, '0); tick();
    check("t6_tag1", dis_tag, 1);

    // Random traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 6) begin
        dis_we = 1;
        dis_val = NBANK'($urandom);
        dis_pc = $urandom;
        dis_data = {$urandom, $urandom};
        for (int k = 0; k < NBANK; k++)
          dis_brmask[k*WIDTH_BRM +: WIDTH_BRM] = ($urandom_range(0, 3) == 0) ? WIDTH_BRM'(1 << $urandom_range(0, 3)) : '0;
      end
      for (int p = 0; p < NWB; p++) begin
        int row;
        wb_val[p] = ($urandom_range(0, 9) < 7);
        row = (m_count > 0) ? (m_head + $urandom_range(0, m_count - 1)) % DEPTH : $urandom_range(0, DEPTH - 1);
        wb_tag[p*TW +: TW] = TW'(row*NBANK + $urandom_range(0, NBANK - 1));
        wb_exc[p] = ($urandom_range(0, 23) == 0);
      end
      if ($urandom_range(0, 7) == 0) br_clr = WIDTH_BRM'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) begin
        kill_en = 1;
        kill_mask = WIDTH_BRM'(1 << $urandom_range(0, 3)) & ~br_clr;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
